// File: rtl/ack_bus_pkg.sv
// Shared definitions for the ACK bus and its per-module requesters.
//   ACK_ID_W        width of a bus source ID
//   ID_MEM..ID_CTRL fixed source IDs; lower ID wins arbitration
//   req_state_t     requester FSM states
package ack_bus_pkg;

    localparam int ACK_ID_W = 2;

    localparam logic [ACK_ID_W-1:0] ID_MEM  = 2'b00;
    localparam logic [ACK_ID_W-1:0] ID_SHA  = 2'b01;
    localparam logic [ACK_ID_W-1:0] ID_AES  = 2'b10;
    localparam logic [ACK_ID_W-1:0] ID_CTRL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        YIELD = 2'd2
    } req_state_t;

endpackage

// File: rtl/ack_tag_fifo.sv
// Pending-ack tag queue: DEPTH x TAG_W circular buffer.
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_tag at tail (ignored while full)
//   pop          advance head (ignored while empty)
//   push_tag     tag to enqueue
//   head_tag     tag at head of queue
//   count        entries queued, 0..DEPTH
//   full, empty  queue status
// Full is taken from the registered count, so a push at full is refused even
// when a pop happens in the same cycle.
module ack_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [TAG_W-1:0]         push_tag,
    output logic [TAG_W-1:0]         head_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign count    = count_reg;
    assign head_tag = mem[rd_ptr_reg];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_tag;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ack_requester.sv
// Per-engine front end to the shared ACK bus. Queues completion tags, raises
// req toward the arbiter, pops one tag per grant, then holds req low for a
// short yield window so other sources get a turn.
//   clk, rst_n        clock, asynchronous active-low reset
//   done_pulse        engine completion strobe
//   done_tag          tag captured with done_pulse
//   req               request to the ACK bus arbiter (decode of state)
//   ack_ready         grant for this module from the arbiter
//   ack_event         bus-wide ACK event
//   winner_source_id  bus-wide winner ID
//   ack_sent          one-cycle pulse: head entry granted and popped
//   ack_sent_tag      popped tag, valid with ack_sent
//   pending_count     entries queued
//   full              queue full
//   overflow          sticky: completion dropped while full
//   starve            sticky: waited STARVE_LIMIT cycles without grant
//   protocol_err      sticky: grant/winner inconsistency seen
module ack_requester
    import ack_bus_pkg::*;
#(
    parameter logic [ACK_ID_W-1:0] SOURCE_ID    = ID_MEM,
    parameter int                  DEPTH        = 4,
    parameter int                  TAG_W        = 4,
    parameter int                  YIELD_CYCLES = 1,
    parameter int                  STARVE_LIMIT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     done_pulse,
    input  logic [TAG_W-1:0]         done_tag,
    output logic                     req,
    input  logic                     ack_ready,
    input  logic                     ack_event,
    input  logic [ACK_ID_W-1:0]      winner_source_id,
    output logic                     ack_sent,
    output logic [TAG_W-1:0]         ack_sent_tag,
    output logic [$clog2(DEPTH):0]   pending_count,
    output logic                     full,
    output logic                     overflow,
    output logic                     starve,
    output logic                     protocol_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int YC_W  = $clog2(YIELD_CYCLES + 1) + 1;

    req_state_t       state_reg, state_next;
    logic [YC_W-1:0]  yield_cnt_reg, yield_cnt_next;
    logic [15:0]      wait_cnt_reg, wait_cnt_next;
    logic             ack_sent_reg;
    logic [TAG_W-1:0] ack_sent_tag_reg;
    logic             overflow_reg;
    logic             starve_reg;
    logic             protocol_err_reg;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [TAG_W-1:0] head_tag;
    logic             push_ok;
    logic             pop;
    logic             winner_match;
    logic             grant_err;
    logic             starve_hit;

    ack_tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (done_pulse),
        .pop      (pop),
        .push_tag (done_tag),
        .head_tag (head_tag),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign req     = (state_reg == REQ);
    assign push_ok = done_pulse && !fifo_full;
    assign pop     = req && ack_ready;

    assign winner_match = ack_event && (winner_source_id == SOURCE_ID);
    assign grant_err    = (ack_ready && !req)
                        || (ack_ready && !winner_match)
                        || (winner_match && !ack_ready);

    // The request decision looks at the queue as it will be after this edge,
    // so a completion strobe raises req on the very next cycle.
    always_comb begin
        state_next     = state_reg;
        yield_cnt_next = yield_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty || push_ok) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ack_ready) begin
                    if (YIELD_CYCLES == 0) begin
                        state_next = ((fifo_count > CNT_W'(1)) || push_ok) ? REQ : IDLE;
                    end else begin
                        state_next     = YIELD;
                        yield_cnt_next = YC_W'(YIELD_CYCLES);
                    end
                end
            end
            YIELD: begin
                if (yield_cnt_reg <= YC_W'(1)) begin
                    state_next     = (!fifo_empty || push_ok) ? REQ : IDLE;
                    yield_cnt_next = '0;
                end else begin
                    yield_cnt_next = yield_cnt_reg - YC_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Wait counter saturates so a stuck arbiter cannot wrap it back to zero.
    always_comb begin
        wait_cnt_next = '0;
        if (req && !ack_ready) begin
            wait_cnt_next = (&wait_cnt_reg) ? wait_cnt_reg : wait_cnt_reg + 16'd1;
        end
    end

    assign starve_hit = (STARVE_LIMIT > 0) && (wait_cnt_next == 16'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            yield_cnt_reg    <= '0;
            wait_cnt_reg     <= '0;
            ack_sent_reg     <= 1'b0;
            ack_sent_tag_reg <= '0;
            overflow_reg     <= 1'b0;
            starve_reg       <= 1'b0;
            protocol_err_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            yield_cnt_reg    <= yield_cnt_next;
            wait_cnt_reg     <= wait_cnt_next;
            ack_sent_reg     <= pop;
            ack_sent_tag_reg <= pop ? head_tag : '0;
            if (done_pulse && fifo_full) begin
                overflow_reg <= 1'b1;
            end
            if (starve_hit) begin
                starve_reg <= 1'b1;
            end
            if (grant_err) begin
                protocol_err_reg <= 1'b1;
            end
        end
    end

    assign ack_sent      = ack_sent_reg;
    assign ack_sent_tag  = ack_sent_tag_reg;
    assign pending_count = fifo_count;
    assign full          = fifo_full;
    assign overflow      = overflow_reg;
    assign starve        = starve_reg;
    assign protocol_err  = protocol_err_reg;

endmodule

// File: tb/tb_ack_requester.sv
// Four requesters (MEM/SHA/AES/CTRL) sharing a fixed-priority ACK arbiter
// modelled here: lowest requesting ID wins, combinationally from req.
module tb_ack_requester;
    import ack_bus_pkg::*;

    localparam int N_SRC = 4;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N_SRC-1:0]    done_pulse;
    logic [TAG_W-1:0]    done_tag [N_SRC];
    logic [N_SRC-1:0]    req;
    logic [N_SRC-1:0]    ack_ready;
    logic [N_SRC-1:0]    ack_sent;
    logic [TAG_W-1:0]    ack_sent_tag [N_SRC];
    logic [CNT_W-1:0]    pending_count [N_SRC];
    logic [N_SRC-1:0]    full, overflow, starve, protocol_err;
    logic                ack_event;
    logic [ACK_ID_W-1:0] winner_source_id;
    logic                block_grants;
    logic [N_SRC-1:0]    inject;
    logic [N_SRC-1:0]    grant;

    int vectors = 0;
    int miscompares = 0;
    logic [5:0] exp_q [$];   // expected {source, tag} in bus order

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_req
        ack_requester #(
            .SOURCE_ID    (ACK_ID_W'(gi)),
            .DEPTH        (DEPTH),
            .TAG_W        (TAG_W),
            .YIELD_CYCLES (1),
            .STARVE_LIMIT (8)
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .done_pulse       (done_pulse[gi]),
            .done_tag         (done_tag[gi]),
            .req              (req[gi]),
            .ack_ready        (ack_ready[gi]),
            .ack_event        (ack_event),
            .winner_source_id (winner_source_id),
            .ack_sent         (ack_sent[gi]),
            .ack_sent_tag     (ack_sent_tag[gi]),
            .pending_count    (pending_count[gi]),
            .full             (full[gi]),
            .overflow         (overflow[gi]),
            .starve           (starve[gi]),
            .protocol_err     (protocol_err[gi])
        );
    end

    always_comb begin
        grant            = '0;
        ack_event        = 1'b0;
        winner_source_id = '0;
        if (!block_grants) begin
            for (int i = N_SRC - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant            = '0;
                    grant[i]         = 1'b1;
                    winner_source_id = ACK_ID_W'(i);
                    ack_event        = 1'b1;
                end
            end
        end
        ack_ready = grant | inject;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_wait(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 0);
        repeat (3) tick();
    endtask

    // Scoreboard: every ack_sent must match the next expected {source, tag}.
    always @(negedge clk) begin : mon
        logic [5:0] e;
        if (rst_n) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (ack_sent[i]) begin
                    $display("t=%0t ack src=%0d tag=0x%0h", $time, i, ack_sent_tag[i]);
                    if (exp_q.size() == 0) begin
                        check("ack_unexpected", 32'(ack_sent), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_src_tag", {26'd0, 2'(i), ack_sent_tag[i]}, {26'd0, e});
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        done_pulse   = '0;
        inject       = '0;
        block_grants = 1'b0;
        for (int i = 0; i < N_SRC; i++) done_tag[i] = '0;

        // Reset state
        repeat (2) tick();
        check("rst_req", 32'(req), 0);
        check("rst_ack_sent", 32'(ack_sent), 0);
        check("rst_flags", {16'd0, full, overflow, starve, protocol_err}, 0);
        check("rst_count", 32'(pending_count[0]), 0);
        rst_n = 1'b1;
        tick();

        // 1: single SHA ack
        done_pulse[1] = 1'b1; done_tag[1] = 4'h5;
        exp_q.push_back({ID_SHA, 4'h5});
        tick();
        done_pulse = '0;
        check("s1_req", 32'(req), 32'b0010);
        check("s1_count1", 32'(pending_count[1]), 1);
        tick();
        check("s1_ack_sent", 32'(ack_sent), 32'b0010);
        check("s1_tag", 32'(ack_sent_tag[1]), 5);
        check("s1_count0", 32'(pending_count[1]), 0);
        repeat (2) tick();
        check("s1_flags", {16'd0, full, overflow, starve, protocol_err}, 0);

        // 2: MEM and AES contend, MEM wins first
        done_pulse = 4'b0101; done_tag[0] = 4'hA; done_tag[2] = 4'hC;
        exp_q.push_back({ID_MEM, 4'hA});
        exp_q.push_back({ID_AES, 4'hC});
        tick();
        done_pulse = '0;
        check("s2_req", 32'(req), 32'b0101);
        tick();
        check("s2_first", 32'(ack_sent), 32'b0001);
        check("s2_req_aes", 32'(req), 32'b0100);
        tick();
        check("s2_second", 32'(ack_sent), 32'b0100);
        drain_wait("s2_drain");

        // 3: CTRL slips in during MEM's yield gap
        done_pulse = 4'b1001; done_tag[0] = 4'h1; done_tag[3] = 4'hD;
        exp_q.push_back({ID_MEM, 4'h1});
        exp_q.push_back({ID_CTRL, 4'hD});
        exp_q.push_back({ID_MEM, 4'h2});
        exp_q.push_back({ID_MEM, 4'h3});
        tick();
        done_pulse = 4'b0001; done_tag[0] = 4'h2;
        check("s3_req", 32'(req), 32'b1001);
        tick();
        done_tag[0] = 4'h3;
        check("s3_mem1", 32'(ack_sent), 32'b0001);
        tick();
        done_pulse = '0;
        check("s3_ctrl", 32'(ack_sent), 32'b1000);
        tick();
        check("s3_mem2", 32'(ack_sent), 32'b0001);
        drain_wait("s3_drain");

        // 4: overflow with grants blocked, then drain and wrap
        block_grants = 1'b1;
        for (int k = 0; k < 6; k++) begin
            done_pulse[0] = 1'b1; done_tag[0] = 4'(k + 8);
            if (k < 4) exp_q.push_back({ID_MEM, 4'(k + 8)});
            tick();
            if (k == 3) begin
                check("s4_full4", 32'(full[0]), 1);
                check("s4_no_ovf4", 32'(overflow[0]), 0);
            end
        end
        done_pulse = '0;
        check("s4_overflow", 32'(overflow[0]), 1);
        check("s4_count", 32'(pending_count[0]), 4);
        block_grants = 1'b0;
        drain_wait("s4_drain");
        for (int k = 0; k < 4; k++) begin
            done_pulse[0] = 1'b1; done_tag[0] = 4'(k + 2);
            exp_q.push_back({ID_MEM, 4'(k + 2)});
            tick();
        end
        done_pulse = '0;
        drain_wait("s4_wrap_drain");
        check("s4_count0", 32'(pending_count[0]), 0);

        // 5: starvation on SHA, then a grant to an idle CTRL
        block_grants = 1'b1;
        done_pulse[1] = 1'b1; done_tag[1] = 4'h7;
        exp_q.push_back({ID_SHA, 4'h7});
        tick();
        done_pulse = '0;
        repeat (7) tick();
        check("s5_starve_early", 32'(starve[1]), 0);
        tick();
        check("s5_starve", 32'(starve[1]), 1);
        block_grants = 1'b0;
        drain_wait("s5_drain");
        inject[3] = 1'b1;
        tick();
        inject = '0;
        check("s5_protocol_err", 32'(protocol_err), 32'b1000);

        // 6: reset in REQ with three entries queued
        block_grants = 1'b1;
        for (int k = 0; k < 3; k++) begin
            done_pulse[0] = 1'b1; done_tag[0] = 4'(k + 4);
            tick();
        end
        done_pulse = '0;
        check("s6_count3", 32'(pending_count[0]), 3);
        check("s6_req_pre", 32'(req[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_req_async", 32'(req), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        block_grants = 1'b0;
        tick();
        check("s6_count0", 32'(pending_count[0]), 0);
        check("s6_flags", {16'd0, full, overflow, starve, protocol_err}, 0);
        repeat (5) tick();
        check("s6_req_idle", 32'(req), 0);
        check("s6_ack_none", 32'(ack_sent), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
